// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared FSM/Booth types and iteration counts for mult_div_unit.
// MULTDIV_BOOTH_RADIX4_EN selects radix-4 Booth multiply (16 iterations instead of 32).
package multdiv_pkg;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;
  typedef enum logic [2:0] {NOP, ADD1, SUB1, ADD2, SUB2} booth_op_e;
`ifdef MULTDIV_BOOTH_RADIX4_EN
  localparam int MUL_ITERS = 16;
  localparam int BOOTH_SHIFT = 2;
`else
  localparam int MUL_ITERS = 32;
  localparam int BOOTH_SHIFT = 1;
`endif
  localparam int DIV_ITERS = 32;
endpackage

// File: rtl/booth_recoder.sv
// booth_recoder: maps {mplier[1:0], q_1} to a Booth op; radix-4 when MULTDIV_BOOTH_RADIX4_EN is defined.
module booth_recoder
  import multdiv_pkg::*;
(
  input  logic [2:0] bits,
  output booth_op_e  op
);
`ifdef MULTDIV_BOOTH_RADIX4_EN
  always_comb begin
    op = NOP;
    case (bits)
      3'b001, 3'b010: op = ADD1;
      3'b011:         op = ADD2;
      3'b100:         op = SUB2;
      3'b101, 3'b110: op = SUB1;
      default:        op = NOP;
    endcase
  end
`else
  logic unused_msb;
  assign unused_msb = bits[2];
  assign op = (bits[1:0] == 2'b01) ? ADD1 : (bits[1:0] == 2'b10) ? SUB1 : NOP;
`endif
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed multiply (Booth) / restoring divide beside the ALU.
// Define MULTDIV_BOOTH_RADIX4_EN for radix-4 Booth multiply (RDY in cycle 17 instead of 33).
module mult_div_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             data_busy
);
  localparam int ACC_W = WIDTH + 2;
  localparam int CNT_W = $clog2(DIV_ITERS);
  state_e state, state_nxt;
  booth_op_e op;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc, mcand_x, addend, acc_sum;
  logic [WIDTH-1:0] mplier, opnd, quo, rem, a_mag, b_mag, quo_nxt, quo_signed;
  logic [ACC_W+WIDTH:0] shifted;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH:0] rem_sh, rem_sub;
  logic q_1, neg_q, last, rem_ge, mul_ovf, div_ovf;

  booth_recoder u_recoder (.bits({mplier[1:0], q_1}), .op(op));

  // Two guard bits keep acc +/- 2A from overflowing for the most negative multiplicand.
  assign mcand_x = {{2{opnd[WIDTH-1]}}, opnd};
  assign addend  = (op == ADD1) ? mcand_x : (op == SUB1) ? -mcand_x :
                   (op == ADD2) ? (mcand_x << 1) : (op == SUB2) ? -(mcand_x << 1) : '0;
  assign acc_sum = acc + addend;
  assign shifted = $signed({acc_sum, mplier, q_1}) >>> BOOTH_SHIFT;
  assign product = shifted[2*WIDTH:1];
  assign mul_ovf = ~(&product[2*WIDTH-1:WIDTH-1] | ~|product[2*WIDTH-1:WIDTH-1]);

  assign a_mag      = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign b_mag      = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
  assign rem_sh     = {rem, quo[WIDTH-1]};
  assign rem_sub    = rem_sh - {1'b0, opnd};
  assign rem_ge     = ~rem_sub[WIDTH];
  assign quo_nxt    = {quo[WIDTH-2:0], rem_ge};
  assign quo_signed = neg_q ? -quo_nxt : quo_nxt;
  // A positive quotient with the MSB set can only be 0x80000000 / -1.
  assign div_ovf    = ~neg_q & quo_nxt[WIDTH-1];

  assign last = cnt == ((state == MUL) ? CNT_W'(MUL_ITERS - 1) : CNT_W'(DIV_ITERS - 1));
  assign data_resultRDY = state == DONE;
  assign data_busy      = state != IDLE;

  always_comb begin
    state_nxt = IDLE;
    if (ctrl_MULT) state_nxt = MUL;
    else if (ctrl_DIV) state_nxt = (data_operandB == '0) ? DONE : DIV;
    else if (state == MUL || state == DIV) state_nxt = last ? DONE : state;
  end

  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nxt;

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      cnt            <= '0;
      acc            <= '0;
      mplier         <= '0;
      q_1            <= 1'b0;
      opnd           <= '0;
      quo            <= '0;
      rem            <= '0;
      neg_q          <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (ctrl_MULT) begin
      cnt            <= '0;
      acc            <= '0;
      mplier         <= data_operandB;
      q_1            <= 1'b0;
      opnd           <= data_operandA;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (ctrl_DIV) begin
      cnt            <= '0;
      rem            <= '0;
      quo            <= a_mag;
      opnd           <= b_mag;
      neg_q          <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      data_result    <= '0;
      data_exception <= data_operandB == '0;
    end else if (state == MUL) begin
      cnt    <= cnt + 1'b1;
      acc    <= shifted[ACC_W+WIDTH:WIDTH+1];
      mplier <= shifted[WIDTH:1];
      q_1    <= shifted[0];
      if (last) begin
        data_result    <= product[WIDTH-1:0];
        data_exception <= mul_ovf;
      end
    end else if (state == DIV) begin
      cnt <= cnt + 1'b1;
      rem <= rem_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      quo <= quo_nxt;
      if (last) begin
        data_result    <= quo_signed;
        data_exception <= div_ovf;
      end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench; driver pushes model results, monitor checks outputs every cycle.
module tb_mult_div_unit;
`ifdef MULTDIV_BOOTH_RADIX4_EN
  localparam int MUL_LAT = 17;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          st;
    int          rdy;
    bit          aborted;
    int          end_cyc;
  } exp_t;

  logic clock = 0, reset = 1, ctrl_MULT = 0, ctrl_DIV = 0;
  logic [31:0] data_operandA = '0, data_operandB = '0, data_result;
  logic data_exception, data_resultRDY, data_busy;
  int cyc = 0, passed = 0, total = 0;
  exp_t sb[$];
  logic [31:0] hold_res = '0;
  logic hold_exc = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .data_busy(data_busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
  endtask

  // Reference: plain 64-bit arithmetic and truncating signed division.
  function automatic exp_t model(bit is_mul, logic [31:0] a, logic [31:0] b);
    exp_t e;
    longint p;
    e.st = 0; e.aborted = 0; e.end_cyc = 0;
    if (is_mul) begin
      p = longint'($signed(a)) * longint'($signed(b));
      e.res = p[31:0];
      e.exc = p != longint'($signed(e.res));
      e.rdy = MUL_LAT;
    end else if (b == 0) begin
      e.res = 0; e.exc = 1; e.rdy = 1;
    end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
      e.res = 32'h80000000; e.exc = 1; e.rdy = DIV_LAT;
    end else begin
      e.res = $signed(a) / $signed(b); e.exc = 0; e.rdy = DIV_LAT;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h7FFFFFFF;
      4: return 32'($urandom_range(0, 40)) - 32'd20;
      default: return $urandom;
    endcase
  endfunction

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clock);
      data_operandA = $urandom;
      data_operandB = $urandom;
    end
  endtask

  // Called at a negedge; the following posedge is the start edge (cycle 0 = current cyc).
  task automatic issue(bit m, bit d, logic [31:0] a, logic [31:0] b);
    exp_t e;
    foreach (sb[i])
      if (!sb[i].aborted && sb[i].rdy > cyc) begin
        sb[i].aborted = 1;
        sb[i].end_cyc = cyc;
      end
    e = model(m, a, b);
    e.st = cyc;
    e.rdy += cyc;
    e.end_cyc = e.rdy;
    sb.push_back(e);
    ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b;
    @(negedge clock);
    ctrl_MULT = 0; ctrl_DIV = 0; data_operandA = $urandom; data_operandB = $urandom;
  endtask

  task automatic wait_done();
    int budget = 200;
    while (sb.size() > 0 && budget > 0) begin
      idle(1);
      budget--;
    end
    total++;
    if (sb.size() == 0) passed++;
    else begin
      $display("FAIL timeout cyc=%0d pending=%0d required=0", cyc, sb.size());
      sb.delete();
    end
  endtask

  initial begin : monitor
    bit exp_rdy, exp_busy;
    forever begin
      @(negedge clock);
      #1;
      while (sb.size() > 0 && sb[0].aborted && sb[0].end_cyc < cyc) void'(sb.pop_front());
      exp_rdy  = sb.size() > 0 && !sb[0].aborted && sb[0].rdy == cyc;
      exp_busy = sb.size() > 0 && sb[0].st < cyc;
      if (exp_rdy) begin
        hold_res = sb[0].res;
        hold_exc = sb[0].exc;
      end else if (exp_busy) begin
        hold_res = '0;
        hold_exc = 0;
      end
      check("rdy", 32'(data_resultRDY), 32'(exp_rdy));
      check("busy", 32'(data_busy), 32'(exp_busy));
      check("result", data_result, hold_res);
      check("exception", 32'(data_exception), 32'(hold_exc));
      if (exp_rdy) void'(sb.pop_front());
    end
  end

  initial begin : driver
    int m;
    #1 reset = 0;
    idle(3);
    reset = 1;
    idle(1);
    issue(1, 0, 1343, 100000);             wait_done();
    issue(0, 1, 100000, 1343);             wait_done();
    issue(0, 1, -7, 2);                    wait_done();
    issue(1, 0, 65536, 65536);             wait_done();
    issue(1, 0, -65536, 32768);            wait_done();
    issue(0, 1, 5, 0);                     wait_done();
    issue(0, 1, 32'h80000000, 32'hFFFFFFFF); wait_done();
    issue(1, 0, 3, 4); idle(9); issue(0, 1, 20, 5); wait_done();
    issue(1, 1, 6, 2);                     wait_done();
    issue(1, 0, 7, -9); idle(MUL_LAT - 1); issue(0, 1, -100, 7); wait_done();
    issue(0, 1, 9, 0); issue(1, 0, -4, -5); wait_done();
    issue(1, 0, 123, 456); idle(14);
    reset = 0;
    sb.delete();
    hold_res = '0;
    hold_exc = 0;
    idle(3);
    reset = 1;
    idle(1);
    issue(1, 0, -3, 5);                    wait_done();
    for (int i = 0; i < 60; i++) begin
      m = $urandom_range(0, 2);
      issue(m != 1, m != 0, rand_val(), rand_val());
      if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 40));
      else begin
        wait_done();
        idle($urandom_range(0, 2));
      end
    end
    wait_done();
    idle(2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
